// File: rtl/cache_consts.sv
// Sizing constants shared by the LLC output path: queue depth, read
// credit limit and payload field widths.
package cache_consts;

    localparam int LLC_OUT_FIFO_DEPTH = 2;
    localparam int LLC_MAX_MEM_RD     = 4;
    localparam int LLC_RD_CNT_BITS    = 3;

    localparam int ADDR_BITS = 28;
    localparam int LINE_BITS = 32;
    localparam int ID_BITS   = 4;

endpackage

// File: rtl/cache_types.sv
// Payload structures carried on the four LLC outbound channels.
package cache_types;

    import cache_consts::*;

    typedef struct packed {
        logic [1:0]           coh_msg;
        logic [ID_BITS-1:0]   req_id;
        logic [ID_BITS-1:0]   dest_id;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] line;
    } llc_rsp_out_t;

    typedef struct packed {
        logic [2:0]           coh_msg;
        logic [ID_BITS-1:0]   req_id;
        logic [ID_BITS-1:0]   dest_id;
        logic [ADDR_BITS-1:0] addr;
    } llc_fwd_out_t;

    // hwrite: 1 = writeback, 0 = read
    typedef struct packed {
        logic                 hwrite;
        logic [2:0]           hsize;
        logic [1:0]           hprot;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] line;
    } llc_mem_req_t;

    typedef struct packed {
        logic [1:0]           coh_msg;
        logic [ID_BITS-1:0]   req_id;
        logic [ID_BITS-1:0]   dest_id;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] line;
    } llc_dma_rsp_out_t;

endpackage

// File: rtl/llc_out_chan.sv
// One outbound channel: small in-order FIFO whose head drives a
// valid/ready port with zero-cycle head-to-output latency.
module llc_out_chan #(
    parameter type T     = logic,
    parameter int  DEPTH = 2,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic out_ready,
    input  logic out_enable,
    output logic out_valid,
    output T     out_data,
    output logic full,
    output logic empty,
    output logic drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            pop;
    logic            accept;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign out_valid = !empty && out_enable;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A full queue still takes a push when its head leaves on the same edge.
    assign accept    = push && (!full || pop);
    assign drop      = push && !accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (accept) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/llc_output_encoder.sv
// LLC output encoder: four independent outbound queues plus memory read
// credit tracking, pipeline stall and idle reporting.
module llc_output_encoder
    import cache_consts::*;
    import cache_types::*;
(
    input  logic             clk,
    input  logic             rst,

    input  logic             send_rsp_out,
    input  llc_rsp_out_t     rsp_out_in,
    input  logic             send_fwd_out,
    input  llc_fwd_out_t     fwd_out_in,
    input  logic             send_mem_req,
    input  llc_mem_req_t     mem_req_in,
    input  logic             send_dma_rsp,
    input  llc_dma_rsp_out_t dma_rsp_in,

    output logic             llc_rsp_out_valid_int,
    input  logic             llc_rsp_out_ready_int,
    output llc_rsp_out_t     llc_rsp_out_o,

    output logic             llc_fwd_out_valid_int,
    input  logic             llc_fwd_out_ready_int,
    output llc_fwd_out_t     llc_fwd_out_o,

    output logic             llc_mem_req_valid_int,
    input  logic             llc_mem_req_ready_int,
    output llc_mem_req_t     llc_mem_req_o,

    output logic             llc_dma_rsp_out_valid_int,
    input  logic             llc_dma_rsp_out_ready_int,
    output llc_dma_rsp_out_t llc_dma_rsp_out_o,

    input  logic             mem_rsp_done,
    output logic             out_stall,
    output logic             overflow_err,
    output logic             out_idle
);

    logic [3:0]                 chan_full;
    logic [3:0]                 chan_empty;
    logic [3:0]                 chan_drop;
    logic [LLC_RD_CNT_BITS-1:0] rd_outstanding;
    logic                       mem_gate;
    logic                       mem_rd_pop;
    logic                       rd_dec;
    logic                       rd_underflow;

    // Out of read credits: hold back a read at the head, but let writebacks go.
    assign mem_gate     = !((rd_outstanding == LLC_RD_CNT_BITS'(LLC_MAX_MEM_RD))
                            && !llc_mem_req_o.hwrite);
    assign mem_rd_pop   = llc_mem_req_valid_int && llc_mem_req_ready_int
                          && !llc_mem_req_o.hwrite;
    assign rd_underflow = mem_rsp_done && (rd_outstanding == '0);
    assign rd_dec       = mem_rsp_done && !rd_underflow;

    assign out_stall = |chan_full;
    assign out_idle  = (&chan_empty) && (rd_outstanding == '0);

    llc_out_chan #(.T(llc_rsp_out_t), .DEPTH(LLC_OUT_FIFO_DEPTH)) u_rsp (
        .clk        (clk),
        .rst        (rst),
        .push       (send_rsp_out),
        .push_data  (rsp_out_in),
        .out_ready  (llc_rsp_out_ready_int),
        .out_enable (1'b1),
        .out_valid  (llc_rsp_out_valid_int),
        .out_data   (llc_rsp_out_o),
        .full       (chan_full[0]),
        .empty      (chan_empty[0]),
        .drop       (chan_drop[0])
    );

    llc_out_chan #(.T(llc_fwd_out_t), .DEPTH(LLC_OUT_FIFO_DEPTH)) u_fwd (
        .clk        (clk),
        .rst        (rst),
        .push       (send_fwd_out),
        .push_data  (fwd_out_in),
        .out_ready  (llc_fwd_out_ready_int),
        .out_enable (1'b1),
        .out_valid  (llc_fwd_out_valid_int),
        .out_data   (llc_fwd_out_o),
        .full       (chan_full[1]),
        .empty      (chan_empty[1]),
        .drop       (chan_drop[1])
    );

    llc_out_chan #(.T(llc_mem_req_t), .DEPTH(LLC_OUT_FIFO_DEPTH)) u_mem (
        .clk        (clk),
        .rst        (rst),
        .push       (send_mem_req),
        .push_data  (mem_req_in),
        .out_ready  (llc_mem_req_ready_int),
        .out_enable (mem_gate),
        .out_valid  (llc_mem_req_valid_int),
        .out_data   (llc_mem_req_o),
        .full       (chan_full[2]),
        .empty      (chan_empty[2]),
        .drop       (chan_drop[2])
    );

    llc_out_chan #(.T(llc_dma_rsp_out_t), .DEPTH(LLC_OUT_FIFO_DEPTH)) u_dma (
        .clk        (clk),
        .rst        (rst),
        .push       (send_dma_rsp),
        .push_data  (dma_rsp_in),
        .out_ready  (llc_dma_rsp_out_ready_int),
        .out_enable (1'b1),
        .out_valid  (llc_dma_rsp_out_valid_int),
        .out_data   (llc_dma_rsp_out_o),
        .full       (chan_full[3]),
        .empty      (chan_empty[3]),
        .drop       (chan_drop[3])
    );

    // Response underflow also holds the counter at zero even if a read pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_outstanding <= '0;
            overflow_err   <= 1'b0;
        end else begin
            if ((|chan_drop) || rd_underflow) begin
                overflow_err <= 1'b1;
            end
            if (mem_rd_pop && !rd_dec && !rd_underflow) begin
                rd_outstanding <= rd_outstanding + LLC_RD_CNT_BITS'(1);
            end else if (rd_dec && !mem_rd_pop) begin
                rd_outstanding <= rd_outstanding - LLC_RD_CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_llc_output_encoder.sv
// Self-checking bench for llc_output_encoder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_llc_output_encoder;

    import cache_consts::*;
    import cache_types::*;

    logic             clk;
    logic             rst;
    logic             send_rsp_out, send_fwd_out, send_mem_req, send_dma_rsp;
    llc_rsp_out_t     rsp_out_in;
    llc_fwd_out_t     fwd_out_in;
    llc_mem_req_t     mem_req_in;
    llc_dma_rsp_out_t dma_rsp_in;
    logic             llc_rsp_out_valid_int, llc_rsp_out_ready_int;
    logic             llc_fwd_out_valid_int, llc_fwd_out_ready_int;
    logic             llc_mem_req_valid_int, llc_mem_req_ready_int;
    logic             llc_dma_rsp_out_valid_int, llc_dma_rsp_out_ready_int;
    llc_rsp_out_t     llc_rsp_out_o;
    llc_fwd_out_t     llc_fwd_out_o;
    llc_mem_req_t     llc_mem_req_o;
    llc_dma_rsp_out_t llc_dma_rsp_out_o;
    logic             mem_rsp_done, out_stall, overflow_err, out_idle;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per channel, read credit count, sticky error.
    llc_rsp_out_t     q_rsp[$];
    llc_fwd_out_t     q_fwd[$];
    llc_mem_req_t     q_mem[$];
    llc_dma_rsp_out_t q_dma[$];
    int               m_rd;
    bit               m_err;

    llc_output_encoder dut (
        .clk(clk), .rst(rst),
        .send_rsp_out(send_rsp_out), .rsp_out_in(rsp_out_in),
        .send_fwd_out(send_fwd_out), .fwd_out_in(fwd_out_in),
        .send_mem_req(send_mem_req), .mem_req_in(mem_req_in),
        .send_dma_rsp(send_dma_rsp), .dma_rsp_in(dma_rsp_in),
        .llc_rsp_out_valid_int(llc_rsp_out_valid_int), .llc_rsp_out_ready_int(llc_rsp_out_ready_int),
        .llc_rsp_out_o(llc_rsp_out_o),
        .llc_fwd_out_valid_int(llc_fwd_out_valid_int), .llc_fwd_out_ready_int(llc_fwd_out_ready_int),
        .llc_fwd_out_o(llc_fwd_out_o),
        .llc_mem_req_valid_int(llc_mem_req_valid_int), .llc_mem_req_ready_int(llc_mem_req_ready_int),
        .llc_mem_req_o(llc_mem_req_o),
        .llc_dma_rsp_out_valid_int(llc_dma_rsp_out_valid_int),
        .llc_dma_rsp_out_ready_int(llc_dma_rsp_out_ready_int),
        .llc_dma_rsp_out_o(llc_dma_rsp_out_o),
        .mem_rsp_done(mem_rsp_done), .out_stall(out_stall),
        .overflow_err(overflow_err), .out_idle(out_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic llc_rsp_out_t rand_rsp();
        llc_rsp_out_t r;
        r.coh_msg = 2'($urandom); r.req_id = 4'($urandom); r.dest_id = 4'($urandom);
        r.addr = 28'($urandom); r.line = $urandom;
        return r;
    endfunction

    function automatic llc_fwd_out_t rand_fwd();
        llc_fwd_out_t r;
        r.coh_msg = 3'($urandom); r.req_id = 4'($urandom); r.dest_id = 4'($urandom);
        r.addr = 28'($urandom);
        return r;
    endfunction

    function automatic llc_mem_req_t rand_mem(input bit hw);
        llc_mem_req_t r;
        r.hwrite = hw; r.hsize = 3'($urandom); r.hprot = 2'($urandom);
        r.addr = 28'($urandom); r.line = $urandom;
        return r;
    endfunction

    function automatic llc_dma_rsp_out_t rand_dma();
        llc_dma_rsp_out_t r;
        r.coh_msg = 2'($urandom); r.req_id = 4'($urandom); r.dest_id = 4'($urandom);
        r.addr = 28'($urandom); r.line = $urandom;
        return r;
    endfunction

    function automatic bit mem_may_issue();
        return (q_mem.size() > 0) && !((m_rd == LLC_MAX_MEM_RD) && !q_mem[0].hwrite);
    endfunction

    function automatic bit any_full();
        return (q_rsp.size() == 2) || (q_fwd.size() == 2) || (q_mem.size() == 2) || (q_dma.size() == 2);
    endfunction

    function automatic bit all_idle();
        return (q_rsp.size() == 0) && (q_fwd.size() == 0) && (q_mem.size() == 0)
               && (q_dma.size() == 0) && (m_rd == 0);
    endfunction

    task automatic clear_inputs();
        send_rsp_out = 0; send_fwd_out = 0; send_mem_req = 0; send_dma_rsp = 0;
        mem_rsp_done = 0;
    endtask

    task automatic clear_model();
        q_rsp.delete(); q_fwd.delete(); q_mem.delete(); q_dma.delete();
        m_rd = 0; m_err = 0;
    endtask

    // Advance the model by one edge using the current inputs, then the DUT.
    task automatic tick();
        bit p_rsp, p_fwd, p_mem, p_dma, rd_pop;
        p_rsp  = (q_rsp.size() > 0) && llc_rsp_out_ready_int;
        p_fwd  = (q_fwd.size() > 0) && llc_fwd_out_ready_int;
        p_mem  = mem_may_issue() && llc_mem_req_ready_int;
        p_dma  = (q_dma.size() > 0) && llc_dma_rsp_out_ready_int;
        rd_pop = p_mem && !q_mem[0].hwrite;
        if (p_rsp) void'(q_rsp.pop_front());
        if (p_fwd) void'(q_fwd.pop_front());
        if (p_mem) void'(q_mem.pop_front());
        if (p_dma) void'(q_dma.pop_front());
        if (send_rsp_out) begin if (q_rsp.size() < 2) q_rsp.push_back(rsp_out_in); else m_err = 1; end
        if (send_fwd_out) begin if (q_fwd.size() < 2) q_fwd.push_back(fwd_out_in); else m_err = 1; end
        if (send_mem_req) begin if (q_mem.size() < 2) q_mem.push_back(mem_req_in); else m_err = 1; end
        if (send_dma_rsp) begin if (q_dma.size() < 2) q_dma.push_back(dma_rsp_in); else m_err = 1; end
        if (mem_rsp_done && m_rd == 0) m_err = 1;
        else if (rd_pop && !mem_rsp_done) m_rd++;
        else if (!rd_pop && mem_rsp_done) m_rd--;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 0;
        clear_inputs();
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if ({llc_rsp_out_valid_int, llc_fwd_out_valid_int, llc_mem_req_valid_int, llc_dma_rsp_out_valid_int} !== 4'b0) begin
            errors++; $display("[TB] FAIL reset_valids got=%b exp=0000", {llc_rsp_out_valid_int, llc_fwd_out_valid_int, llc_mem_req_valid_int, llc_dma_rsp_out_valid_int}); end
        checks++; if ({out_stall, overflow_err, out_idle} !== 3'b001) begin
            errors++; $display("[TB] FAIL reset_status stall/err/idle got=%b exp=001", {out_stall, overflow_err, out_idle}); end
        checks++; if (dut.rd_outstanding !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_rd_outstanding got=%0d exp=0", dut.rd_outstanding); end
        checks++; if ((llc_rsp_out_o !== '0) || (llc_fwd_out_o !== '0) || (llc_mem_req_o !== '0) || (llc_dma_rsp_out_o !== '0)) begin
            errors++; $display("[TB] FAIL reset_payloads got rsp=%h fwd=%h mem=%h dma=%h exp=0", llc_rsp_out_o, llc_fwd_out_o, llc_mem_req_o, llc_dma_rsp_out_o); end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_rsp();
        llc_rsp_out_t e;
        e = rand_rsp();
        rsp_out_in = e; send_rsp_out = 1;
        tick();
        send_rsp_out = 0; rsp_out_in = rand_rsp();
        checks++; if (llc_rsp_out_valid_int !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_rise got=%b exp=1", llc_rsp_out_valid_int); end
        checks++; if (llc_rsp_out_o !== e) begin errors++; $display("[TB] FAIL single_payload got=%h exp=%h", llc_rsp_out_o, e); end
        checks++; if (out_idle !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy got=%b exp=0", out_idle); end
        tick();
        checks++; if (llc_rsp_out_valid_int !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_fall got=%b exp=0", llc_rsp_out_valid_int); end
        checks++; if (out_idle !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_back got=%b exp=1", out_idle); end
    endtask

    task automatic test_fwd_overflow();
        llc_fwd_out_t e[3];
        llc_fwd_out_ready_int = 0;
        for (int i = 0; i < 3; i++) begin
            e[i] = rand_fwd();
            fwd_out_in = e[i]; send_fwd_out = 1;
            tick();
            if (i == 1) begin
                checks++; if (out_stall !== 1'b1) begin errors++; $display("[TB] FAIL fwd_stall_full got=%b exp=1", out_stall); end
                checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL fwd_err_before_drop got=%b exp=0", overflow_err); end
            end
        end
        send_fwd_out = 0;
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL fwd_err_after_drop got=%b exp=1", overflow_err); end
        checks++; if (llc_fwd_out_o !== e[0]) begin errors++; $display("[TB] FAIL fwd_head_first got=%h exp=%h", llc_fwd_out_o, e[0]); end
        llc_fwd_out_ready_int = 1;
        tick();
        checks++; if ((llc_fwd_out_valid_int !== 1'b1) || (llc_fwd_out_o !== e[1])) begin
            errors++; $display("[TB] FAIL fwd_head_second got=%b/%h exp=1/%h", llc_fwd_out_valid_int, llc_fwd_out_o, e[1]); end
        tick();
        checks++; if (llc_fwd_out_valid_int !== 1'b0) begin errors++; $display("[TB] FAIL fwd_drained got=%b exp=0", llc_fwd_out_valid_int); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL fwd_err_sticky got=%b exp=1", overflow_err); end
        apply_reset();
    endtask

    task automatic test_mem_reads();
        llc_mem_req_t last;
        llc_mem_req_ready_int = 1;
        for (int i = 0; i < 5; i++) begin
            last = rand_mem(0);
            mem_req_in = last; send_mem_req = 1;
            tick();
        end
        send_mem_req = 0;
        checks++; if (dut.rd_outstanding !== 3'd4) begin errors++; $display("[TB] FAIL mem_rd_at_max got=%0d exp=4", dut.rd_outstanding); end
        checks++; if (llc_mem_req_valid_int !== 1'b0) begin errors++; $display("[TB] FAIL mem_fifth_blocked got=%b exp=0", llc_mem_req_valid_int); end
        tick();
        checks++; if ((llc_mem_req_valid_int !== 1'b0) || (llc_mem_req_o !== last)) begin
            errors++; $display("[TB] FAIL mem_blocked_hold got=%b/%h exp=0/%h", llc_mem_req_valid_int, llc_mem_req_o, last); end
        mem_rsp_done = 1;
        tick();
        mem_rsp_done = 0;
        checks++; if ((llc_mem_req_valid_int !== 1'b1) || (dut.rd_outstanding !== 3'd3)) begin
            errors++; $display("[TB] FAIL mem_credit_return valid/rd got=%b/%0d exp=1/3", llc_mem_req_valid_int, dut.rd_outstanding); end
        tick();
        checks++; if ((dut.rd_outstanding !== 3'd4) || (llc_mem_req_valid_int !== 1'b0)) begin
            errors++; $display("[TB] FAIL mem_back_to_max valid/rd got=%b/%0d exp=0/4", llc_mem_req_valid_int, dut.rd_outstanding); end
        mem_req_in = rand_mem(1); send_mem_req = 1;
        tick();
        send_mem_req = 0;
        checks++; if (llc_mem_req_valid_int !== 1'b1) begin errors++; $display("[TB] FAIL mem_writeback_not_gated got=%b exp=1", llc_mem_req_valid_int); end
        tick();
        checks++; if (dut.rd_outstanding !== 3'd4) begin errors++; $display("[TB] FAIL mem_writeback_no_credit got=%0d exp=4", dut.rd_outstanding); end
        mem_rsp_done = 1;
        repeat (4) tick();
        mem_rsp_done = 0;
        checks++; if ((dut.rd_outstanding !== 3'd0) || (out_idle !== 1'b1)) begin
            errors++; $display("[TB] FAIL mem_drained rd/idle got=%0d/%b exp=0/1", dut.rd_outstanding, out_idle); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL mem_no_err_yet got=%b exp=0", overflow_err); end
        mem_rsp_done = 1;
        tick();
        mem_rsp_done = 0;
        checks++; if ((dut.rd_outstanding !== 3'd0) || (overflow_err !== 1'b1)) begin
            errors++; $display("[TB] FAIL mem_underflow rd/err got=%0d/%b exp=0/1", dut.rd_outstanding, overflow_err); end
        apply_reset();
    endtask

    task automatic test_full_push_pop();
        llc_rsp_out_t e[3];
        llc_rsp_out_ready_int = 0;
        for (int i = 0; i < 3; i++) e[i] = rand_rsp();
        for (int i = 0; i < 2; i++) begin
            rsp_out_in = e[i]; send_rsp_out = 1;
            tick();
        end
        checks++; if ((out_stall !== 1'b1) || (dut.u_rsp.count !== 2'd2)) begin
            errors++; $display("[TB] FAIL full_before stall/count got=%b/%0d exp=1/2", out_stall, dut.u_rsp.count); end
        llc_rsp_out_ready_int = 1;
        rsp_out_in = e[2];
        tick();
        send_rsp_out = 0;
        checks++; if ((dut.u_rsp.count !== 2'd2) || (out_stall !== 1'b1)) begin
            errors++; $display("[TB] FAIL full_pushpop count/stall got=%0d/%b exp=2/1", dut.u_rsp.count, out_stall); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL full_pushpop_err got=%b exp=0", overflow_err); end
        checks++; if (llc_rsp_out_o !== e[1]) begin errors++; $display("[TB] FAIL full_pushpop_head got=%h exp=%h", llc_rsp_out_o, e[1]); end
        tick();
        checks++; if ((llc_rsp_out_valid_int !== 1'b1) || (llc_rsp_out_o !== e[2])) begin
            errors++; $display("[TB] FAIL full_pushpop_third got=%b/%h exp=1/%h", llc_rsp_out_valid_int, llc_rsp_out_o, e[2]); end
        tick();
        checks++; if (out_idle !== 1'b1) begin errors++; $display("[TB] FAIL full_pushpop_idle got=%b exp=1", out_idle); end
    endtask

    task automatic test_independence();
        llc_dma_rsp_out_t d;
        d = rand_dma();
        llc_dma_rsp_out_ready_int = 0;
        llc_rsp_out_ready_int = 1;
        dma_rsp_in = d; send_dma_rsp = 1;
        tick();
        send_dma_rsp = 0; dma_rsp_in = rand_dma();
        for (int i = 0; i < 6; i++) begin
            rsp_out_in = rand_rsp(); send_rsp_out = 1;
            tick();
            checks++; if ((llc_dma_rsp_out_valid_int !== 1'b1) || (llc_dma_rsp_out_o !== d)) begin
                errors++; $display("[TB] FAIL indep_dma_hold cyc=%0d got=%b/%h exp=1/%h", i, llc_dma_rsp_out_valid_int, llc_dma_rsp_out_o, d); end
            checks++; if ((llc_rsp_out_valid_int !== 1'b1) || (llc_rsp_out_o !== q_rsp[0])) begin
                errors++; $display("[TB] FAIL indep_rsp_flow cyc=%0d got=%b/%h exp=1/%h", i, llc_rsp_out_valid_int, llc_rsp_out_o, q_rsp[0]); end
        end
        send_rsp_out = 0;
        llc_dma_rsp_out_ready_int = 1;
        tick();
        checks++; if ((llc_dma_rsp_out_valid_int !== 1'b0) || (out_idle !== 1'b1)) begin
            errors++; $display("[TB] FAIL indep_drain dma_valid/idle got=%b/%b exp=0/1", llc_dma_rsp_out_valid_int, out_idle); end
    endtask

    task automatic test_reset_mid();
        llc_rsp_out_ready_int = 1; llc_fwd_out_ready_int = 1;
        llc_mem_req_ready_int = 1; llc_dma_rsp_out_ready_int = 1;
        for (int i = 0; i < 3; i++) begin
            mem_req_in = rand_mem(0); send_mem_req = 1;
            tick();
        end
        send_mem_req = 0;
        tick();
        llc_rsp_out_ready_int = 0; llc_fwd_out_ready_int = 0;
        llc_mem_req_ready_int = 0; llc_dma_rsp_out_ready_int = 0;
        for (int i = 0; i < 2; i++) begin
            rsp_out_in = rand_rsp(); fwd_out_in = rand_fwd();
            mem_req_in = rand_mem(0); dma_rsp_in = rand_dma();
            send_rsp_out = 1; send_fwd_out = 1; send_mem_req = 1; send_dma_rsp = 1;
            tick();
        end
        clear_inputs();
        checks++; if ((dut.rd_outstanding !== 3'd3) || (out_stall !== 1'b1)) begin
            errors++; $display("[TB] FAIL midrst_setup rd/stall got=%0d/%b exp=3/1", dut.rd_outstanding, out_stall); end
        #2;
        rst = 0;
        clear_model();
        llc_rsp_out_ready_int = 1; llc_fwd_out_ready_int = 1;
        llc_mem_req_ready_int = 1; llc_dma_rsp_out_ready_int = 1;
        #1;
        checks++; if ({llc_rsp_out_valid_int, llc_fwd_out_valid_int, llc_mem_req_valid_int, llc_dma_rsp_out_valid_int} !== 4'b0) begin
            errors++; $display("[TB] FAIL midrst_valids got=%b exp=0000", {llc_rsp_out_valid_int, llc_fwd_out_valid_int, llc_mem_req_valid_int, llc_dma_rsp_out_valid_int}); end
        checks++; if ((out_idle !== 1'b1) || (dut.rd_outstanding !== 3'd0) || (out_stall !== 1'b0)) begin
            errors++; $display("[TB] FAIL midrst_status idle/rd/stall got=%b/%0d/%b exp=1/0/0", out_idle, dut.rd_outstanding, out_stall); end
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        tick();
        checks++; if ({llc_rsp_out_valid_int, llc_fwd_out_valid_int, llc_mem_req_valid_int, llc_dma_rsp_out_valid_int, out_idle} !== 5'b00001) begin
            errors++; $display("[TB] FAIL midrst_after valids+idle got=%b exp=00001", {llc_rsp_out_valid_int, llc_fwd_out_valid_int, llc_mem_req_valid_int, llc_dma_rsp_out_valid_int, out_idle}); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            send_rsp_out = 1'($urandom); send_fwd_out = 1'($urandom);
            send_mem_req = 1'($urandom); send_dma_rsp = 1'($urandom);
            rsp_out_in = rand_rsp(); fwd_out_in = rand_fwd();
            mem_req_in = rand_mem(1'($urandom)); dma_rsp_in = rand_dma();
            llc_rsp_out_ready_int     = ($urandom_range(0, 3) != 0);
            llc_fwd_out_ready_int     = ($urandom_range(0, 3) != 0);
            llc_mem_req_ready_int     = ($urandom_range(0, 3) != 0);
            llc_dma_rsp_out_ready_int = ($urandom_range(0, 3) != 0);
            mem_rsp_done = (m_rd > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            tick();
            checks++; if (llc_rsp_out_valid_int !== (q_rsp.size() > 0)) begin
                errors++; $display("[TB] FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", c, llc_rsp_out_valid_int, q_rsp.size() > 0); end
            if (q_rsp.size() > 0) begin checks++; if (llc_rsp_out_o !== q_rsp[0]) begin
                errors++; $display("[TB] FAIL rand_rsp_data cyc=%0d got=%h exp=%h", c, llc_rsp_out_o, q_rsp[0]); end end
            checks++; if (llc_fwd_out_valid_int !== (q_fwd.size() > 0)) begin
                errors++; $display("[TB] FAIL rand_fwd_valid cyc=%0d got=%b exp=%b", c, llc_fwd_out_valid_int, q_fwd.size() > 0); end
            if (q_fwd.size() > 0) begin checks++; if (llc_fwd_out_o !== q_fwd[0]) begin
                errors++; $display("[TB] FAIL rand_fwd_data cyc=%0d got=%h exp=%h", c, llc_fwd_out_o, q_fwd[0]); end end
            checks++; if (llc_mem_req_valid_int !== mem_may_issue()) begin
                errors++; $display("[TB] FAIL rand_mem_valid cyc=%0d got=%b exp=%b", c, llc_mem_req_valid_int, mem_may_issue()); end
            if (q_mem.size() > 0) begin checks++; if (llc_mem_req_o !== q_mem[0]) begin
                errors++; $display("[TB] FAIL rand_mem_data cyc=%0d got=%h exp=%h", c, llc_mem_req_o, q_mem[0]); end end
            checks++; if (llc_dma_rsp_out_valid_int !== (q_dma.size() > 0)) begin
                errors++; $display("[TB] FAIL rand_dma_valid cyc=%0d got=%b exp=%b", c, llc_dma_rsp_out_valid_int, q_dma.size() > 0); end
            if (q_dma.size() > 0) begin checks++; if (llc_dma_rsp_out_o !== q_dma[0]) begin
                errors++; $display("[TB] FAIL rand_dma_data cyc=%0d got=%h exp=%h", c, llc_dma_rsp_out_o, q_dma[0]); end end
            checks++; if ({out_stall, overflow_err, out_idle} !== {any_full(), m_err, all_idle()}) begin
                errors++; $display("[TB] FAIL rand_status cyc=%0d stall/err/idle got=%b exp=%b", c, {out_stall, overflow_err, out_idle}, {any_full(), m_err, all_idle()}); end
            checks++; if (dut.rd_outstanding !== 3'(m_rd)) begin
                errors++; $display("[TB] FAIL rand_rd_outstanding cyc=%0d got=%0d exp=%0d", c, dut.rd_outstanding, m_rd); end
        end
        clear_inputs();
    endtask

    initial begin
        clk = 0;
        rst = 1;
        clear_inputs();
        clear_model();
        rsp_out_in = '0; fwd_out_in = '0; mem_req_in = '0; dma_rsp_in = '0;
        llc_rsp_out_ready_int = 1; llc_fwd_out_ready_int = 1;
        llc_mem_req_ready_int = 1; llc_dma_rsp_out_ready_int = 1;
        #1 rst = 0;
        #1;
        test_reset();
        test_single_rsp();
        test_fwd_overflow();
        test_mem_reads();
        test_full_push_pop();
        test_independence();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
